// File: rtl/paicore_loop_seq.sv
// Run-level SEND/RECV sequencer for the PAICORE loopback datapath: config latching, inbound
// stream gating and per-phase inactivity watchdog. Define PAICORE_SEQ_PERF_EN for phase cycle counters.
module paicore_loop_seq #(
  parameter int unsigned          TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 24'd1000000,
  parameter int unsigned          ITER_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       cfg_send_len,
  input  logic [31:0]       cfg_frame_max,
  input  logic              cfg_fork_en,
  input  logic [ITER_W-1:0] cfg_repeat,
  output logic [31:0]       send_len,
  output logic [31:0]       oFrameNumMax,
  output logic              fork_enable,
  input  logic              tx_done,
  input  logic              rx_done,
  input  logic              tx_hsk,
  input  logic              rx_hsk,
  input  logic              up_tvalid,
  output logic              up_tready,
  output logic              dn_tvalid,
  input  logic              dn_tready,
  output logic              busy,
  output logic              run_done,
  output logic              err_timeout,
  output logic              err_phase,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [2:0]        state_o
`ifdef PAICORE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_tx_cyc,
  output logic [31:0]       perf_rx_cyc
`endif
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StSend  = 3'd2,
    StRecv  = 3'd3,
    StNext  = 3'd4,
    StFault = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        send_len_q, send_len_d;
  logic [31:0]        frame_max_q, frame_max_d;
  logic               fork_q, fork_d;
  logic [ITER_W-1:0]  rep_q, rep_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               err_to_q, err_to_d;
  logic               err_ph_q, err_ph_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  logic               start_ok;
  logic               wd_hit;
  logic               last_iter;
  logic [TIMEOUT_W-1:0] wd_inc;

  assign start_ok  = (state_q == StIdle) && start && !abort;
  assign wd_hit    = wd_q >= (TIMEOUT_CYC - TIMEOUT_W'(1));
  assign wd_inc    = (wd_q == '1) ? wd_q : wd_q + TIMEOUT_W'(1);
  // Compare one bit wider so the final iteration is detected even at the counter's top value.
  assign last_iter = ({1'b0, iter_q} + (ITER_W + 1)'(1)) >= {1'b0, rep_q};

  always_comb begin
    state_d     = state_q;
    send_len_d  = send_len_q;
    frame_max_d = frame_max_q;
    fork_d      = fork_q;
    rep_d       = rep_q;
    iter_d      = iter_q;
    err_to_d    = err_to_q;
    err_ph_d    = err_ph_q;
    wd_d        = wd_q;
    run_done    = 1'b0;

    if (abort) begin
      state_d = StIdle;
      wd_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wd_d = '0;
          if (start) begin
            send_len_d  = cfg_send_len;
            frame_max_d = cfg_frame_max;
            fork_d      = cfg_fork_en;
            rep_d       = (cfg_repeat == '0) ? ITER_W'(1) : cfg_repeat;
            iter_d      = '0;
            err_ph_d    = 1'b0;
            if (cfg_send_len == 32'd0) begin
              err_to_d = 1'b1;
              state_d  = StFault;
            end else begin
              err_to_d = 1'b0;
              state_d  = StLoad;
            end
          end
        end
        StLoad: begin
          wd_d    = '0;
          state_d = StSend;
        end
        StSend: begin
          if (tx_done) begin
            wd_d    = '0;
            state_d = rx_done ? StNext : StRecv;
          end else if (tx_hsk) begin
            wd_d = '0;
          end else if (wd_hit) begin
            err_to_d = 1'b1;
            err_ph_d = 1'b0;
            state_d  = StFault;
          end else begin
            wd_d = wd_inc;
          end
        end
        StRecv: begin
          if (rx_done) begin
            wd_d    = '0;
            state_d = StNext;
          end else if (rx_hsk) begin
            wd_d = '0;
          end else if (wd_hit) begin
            err_to_d = 1'b1;
            err_ph_d = 1'b1;
            state_d  = StFault;
          end else begin
            wd_d = wd_inc;
          end
        end
        StNext: begin
          wd_d   = '0;
          iter_d = iter_q + ITER_W'(1);
          if (last_iter) begin
            run_done = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
        StFault: begin
          wd_d = '0;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      send_len_q  <= '0;
      frame_max_q <= '0;
      fork_q      <= 1'b0;
      rep_q       <= '0;
      iter_q      <= '0;
      err_to_q    <= 1'b0;
      err_ph_q    <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      send_len_q  <= send_len_d;
      frame_max_q <= frame_max_d;
      fork_q      <= fork_d;
      rep_q       <= rep_d;
      iter_q      <= iter_d;
      err_to_q    <= err_to_d;
      err_ph_q    <= err_ph_d;
      wd_q        <= wd_d;
    end
  end

  // Gate is a pure pass-through in SEND so no word is held or replayed across a phase edge.
  always_comb begin
    up_tready = 1'b0;
    dn_tvalid = 1'b0;
    if (state_q == StSend) begin
      up_tready = dn_tready;
      dn_tvalid = up_tvalid;
    end
  end

  assign send_len     = send_len_q;
  assign oFrameNumMax = frame_max_q;
  assign fork_enable  = fork_q;
  assign busy         = (state_q != StIdle);
  assign err_timeout  = err_to_q;
  assign err_phase    = err_ph_q;
  assign iter_cnt     = iter_q;
  assign state_o      = state_q;

`ifdef PAICORE_SEQ_PERF_EN
  logic [31:0] perf_tx_q, perf_tx_d;
  logic [31:0] perf_rx_q, perf_rx_d;

  always_comb begin
    perf_tx_d = perf_tx_q;
    perf_rx_d = perf_rx_q;
    if (start_ok) begin
      perf_tx_d = '0;
      perf_rx_d = '0;
    end else begin
      if ((state_q == StSend) && (perf_tx_q != '1)) perf_tx_d = perf_tx_q + 32'd1;
      if ((state_q == StRecv) && (perf_rx_q != '1)) perf_rx_d = perf_rx_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_tx_q <= '0;
      perf_rx_q <= '0;
    end else begin
      perf_tx_q <= perf_tx_d;
      perf_rx_q <= perf_rx_d;
    end
  end

  assign perf_tx_cyc = perf_tx_q;
  assign perf_rx_cyc = perf_rx_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_paicore_loop_seq.sv
// Randomized self-checking bench for paicore_loop_seq with a transaction-level run model.
module tb_paicore_loop_seq;

  localparam int unsigned IW = 16;

  logic          clk, rst, start, abort;
  logic [31:0]   cfg_send_len, cfg_frame_max;
  logic          cfg_fork_en;
  logic [IW-1:0] cfg_repeat;
  logic [31:0]   send_len, oFrameNumMax;
  logic          fork_enable;
  logic          tx_done, rx_done, tx_hsk, rx_hsk;
  logic          up_tvalid, up_tready, dn_tvalid, dn_tready;
  logic          busy, run_done, err_timeout, err_phase;
  logic [IW-1:0] iter_cnt;
  logic [2:0]    state_o;
`ifdef PAICORE_SEQ_PERF_EN
  logic [31:0]   perf_tx_cyc, perf_rx_cyc;
`endif

  paicore_loop_seq #(
    .TIMEOUT_W  (24),
    .TIMEOUT_CYC(24'd100),
    .ITER_W     (IW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_send_len (cfg_send_len),
    .cfg_frame_max(cfg_frame_max),
    .cfg_fork_en  (cfg_fork_en),
    .cfg_repeat   (cfg_repeat),
    .send_len     (send_len),
    .oFrameNumMax (oFrameNumMax),
    .fork_enable  (fork_enable),
    .tx_done      (tx_done),
    .rx_done      (rx_done),
    .tx_hsk       (tx_hsk),
    .rx_hsk       (rx_hsk),
    .up_tvalid    (up_tvalid),
    .up_tready    (up_tready),
    .dn_tvalid    (dn_tvalid),
    .dn_tready    (dn_tready),
    .busy         (busy),
    .run_done     (run_done),
    .err_timeout  (err_timeout),
    .err_phase    (err_phase),
    .iter_cnt     (iter_cnt),
    .state_o      (state_o)
`ifdef PAICORE_SEQ_PERF_EN
    ,
    .perf_tx_cyc  (perf_tx_cyc),
    .perf_rx_cyc  (perf_rx_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Mid-cycle event counters; the bench snapshots them and compares deltas.
  int up_hs_cnt = 0;
  int dn_hs_cnt = 0;
  int done_cnt  = 0;
  always @(negedge clk) begin
    if (up_tvalid && up_tready) up_hs_cnt++;
    if (dn_tvalid && dn_tready) dn_hs_cnt++;
    if (run_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start = 0; abort = 0; tx_done = 0; rx_done = 0; tx_hsk = 0; rx_hsk = 0;
    up_tvalid = 0; dn_tready = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_flags"}, {26'd0, busy, run_done, err_timeout, err_phase, dn_tvalid, up_tready},
          32'd0);
    check({tag, "_cfg"}, send_len | oFrameNumMax | 32'(fork_enable), 32'd0);
    check({tag, "_iter"}, 32'(iter_cnt), 32'd0);
`ifdef PAICORE_SEQ_PERF_EN
    check({tag, "_perf"}, perf_tx_cyc | perf_rx_cyc, 32'd0);
`endif
  endtask

  // Starts a run and advances into the SEND phase of its first iteration.
  task automatic go_send(input int len, input int rep);
    cfg_send_len = 32'(len); cfg_frame_max = 32'd4; cfg_fork_en = 1'b0; cfg_repeat = IW'(rep);
    start = 1; tick(); start = 0;
    tick();
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      up_tvalid = 1; dn_tready = 1; tx_hsk = 1; tick();
    end
    up_tvalid = 0; dn_tready = 0; tx_hsk = 0;
  endtask

  // One full run: the model is the run's phase schedule chosen here plus the expected totals.
  task automatic do_run(input int len, input int fmax, input bit fork_en, input int rep);
    int eff, hs, guard, exp_tx, exp_rx, b_up, b_dn, b_done;
    bit both, last;
    eff = (rep == 0) ? 1 : rep;
    exp_tx = 0; exp_rx = 0;
    b_up = up_hs_cnt; b_dn = dn_hs_cnt; b_done = done_cnt;
    cfg_send_len = 32'(len); cfg_frame_max = 32'(fmax); cfg_fork_en = fork_en;
    cfg_repeat = IW'(rep);
    start = 1; tick(); start = 0;
    check("start_errs", {30'd0, err_timeout, err_phase}, 32'd0);
    check("start_iter", 32'(iter_cnt), 32'd0);
    for (int it = 0; it < eff; it++) begin
      check("load_state", 32'(state_o), 32'd1);
      up_tvalid = 1; dn_tready = 1;
      tx_done = 1'($urandom_range(1)); rx_done = 1'($urandom_range(1)); #1;
      check("load_gate", {30'd0, dn_tvalid, up_tready}, 32'd0);
      check("load_busy", 32'(busy), 32'd1);
      tick(); tx_done = 0; rx_done = 0;
      check("send_state", 32'(state_o), 32'd2);
      hs = 0; guard = 0;
      while (hs < len && guard < 40 * len + 40) begin
        up_tvalid = 1'($urandom_range(1)); dn_tready = 1'($urandom_range(1));
        tx_hsk = up_tvalid & dn_tready; #1;
        check("send_dn_tvalid", 32'(dn_tvalid), 32'(up_tvalid));
        check("send_up_tready", 32'(up_tready), 32'(dn_tready));
        tick(); hs += int'(tx_hsk); exp_tx++; guard++;
        check("send_hold", 32'(state_o), 32'd2);
      end
      if (hs < len) check("send_budget", 32'(hs), 32'(len));
      up_tvalid = 0; dn_tready = 0; tx_hsk = 0;
      both = ($urandom_range(3) == 0);
      tx_done = 1; rx_done = both;
      tick(); exp_tx++; tx_done = 0; rx_done = 0;
      if (!both) begin
        check("recv_state", 32'(state_o), 32'd3);
        for (int k = 0; k < fmax; k++) begin
          up_tvalid = 1; dn_tready = 1; rx_hsk = 1'($urandom_range(1)); #1;
          check("recv_gate", {30'd0, dn_tvalid, up_tready}, 32'd0);
          tick(); exp_rx++;
          check("recv_hold", 32'(state_o), 32'd3);
        end
        up_tvalid = 0; dn_tready = 0; rx_hsk = 1; rx_done = 1;
        tick(); exp_rx++; rx_done = 0; rx_hsk = 0;
      end
      last = (it == eff - 1);
      check("next_state", 32'(state_o), 32'd4);
      up_tvalid = 1; dn_tready = 1; tx_done = 1'($urandom_range(1)); #1;
      check("next_gate", {30'd0, dn_tvalid, up_tready}, 32'd0);
      check("next_run_done", 32'(run_done), 32'(last));
      check("next_iter", 32'(iter_cnt), 32'(it));
      check("cfg_send_len", send_len, 32'(len));
      check("cfg_frame_max", oFrameNumMax, 32'(fmax));
      check("cfg_fork", 32'(fork_enable), 32'(fork_en));
      tick(); quiet();
      check("post_iter", 32'(iter_cnt), 32'(it + 1));
      check("post_state", 32'(state_o), last ? 32'd0 : 32'd1);
      check("post_busy", 32'(busy), last ? 32'd0 : 32'd1);
    end
    check("run_done_count", 32'(done_cnt - b_done), 32'd1);
    check("up_words", 32'(up_hs_cnt - b_up), 32'(len * eff));
    check("dn_words", 32'(dn_hs_cnt - b_dn), 32'(len * eff));
`ifdef PAICORE_SEQ_PERF_EN
    check("perf_tx", perf_tx_cyc, 32'(exp_tx));
    check("perf_rx", perf_rx_cyc, 32'(exp_rx));
`endif
  endtask

  int b_done;

  initial begin
    quiet();
    rst = 1; cfg_send_len = 0; cfg_frame_max = 0; cfg_fork_en = 0; cfg_repeat = 0;
    tick(); tick();
    up_tvalid = 1; dn_tready = 1; #1;
    check_zero("reset");
    rst = 0; quiet(); tick();

    do_run(16, 8, 1'b0, 1);
    do_run(16, 8, 1'b1, 3);
    for (int r = 0; r < 5; r++) begin
      do_run(int'($urandom_range(24, 1)), int'($urandom_range(12)), 1'($urandom_range(1)),
             int'($urandom_range(3)));
    end

    // Zero-length send faults immediately as a SEND-phase error.
    cfg_send_len = 0; cfg_repeat = 1; start = 1; tick(); start = 0;
    check("len0_state", 32'(state_o), 32'd5);
    check("len0_errs", {30'd0, err_timeout, err_phase}, 32'd2);
    abort = 1; tick(); abort = 0;
    check("len0_abort", 32'(state_o), 32'd0);

    // RECV hang: FAULT exactly TIMEOUT_CYC cycles after entering RECV.
    go_send(4, 1);
    push_words(4);
    tx_done = 1; tick(); tx_done = 0;
    check("to_recv_entry", 32'(state_o), 32'd3);
    up_tvalid = 1;
    repeat (99) tick();
    check("to_recv_edge", 32'(state_o), 32'd3);
    tick();
    check("to_recv_fault", 32'(state_o), 32'd5);
    check("to_recv_errs", {29'd0, busy, err_timeout, err_phase}, 32'd7);
    check("to_fault_gate", {30'd0, dn_tvalid, up_tready}, 32'd0);
    cfg_send_len = 8; start = 1; tick(); start = 0;
    check("fault_ignores_start", 32'(state_o), 32'd5);
    abort = 1; tick(); abort = 0;
    check("fault_abort_state", 32'(state_o), 32'd0);
    check("fault_abort_errs", {30'd0, err_timeout, err_phase}, 32'd3);
    start = 1; tick(); start = 0;
    check("restart_clears", {29'd0, state_o == 3'd1, err_timeout, err_phase}, 32'd4);
    abort = 1; tick(); abort = 0; quiet();

    // SEND hang reports phase 0.
    go_send(4, 1);
    repeat (99) tick();
    check("to_send_edge", 32'(state_o), 32'd2);
    tick();
    check("to_send_fault", {29'd0, state_o}, 32'd5);
    check("to_send_errs", {30'd0, err_timeout, err_phase}, 32'd2);
    abort = 1; tick(); abort = 0;

    // start+abort together in SEND of iteration 2: abort wins, iter_cnt is kept.
    b_done = done_cnt;
    go_send(2, 2);
    push_words(2);
    tx_done = 1; rx_done = 1; tick(); tx_done = 0; rx_done = 0;
    check("both_done_next", 32'(state_o), 32'd4);
    tick(); tick();
    check("iter2_send", 32'(state_o), 32'd2);
    cfg_send_len = 32'd77; start = 1; abort = 1; tick(); quiet();
    check("sa_state", 32'(state_o), 32'd0);
    check("sa_iter", 32'(iter_cnt), 32'd1);
    check("sa_len", send_len, 32'd2);
    check("sa_no_done", 32'(done_cnt - b_done), 32'd0);

    // Synchronous reset in the middle of RECV.
    go_send(1, 1);
    push_words(1);
    tx_done = 1; tick(); tx_done = 0;
    check("rst_pre_recv", 32'(state_o), 32'd3);
    up_tvalid = 1; dn_tready = 1; rst = 1; tick();
    check_zero("rst_recv");
    rst = 0; quiet(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
